fp_ds_32: RTL and testbench

FP_DS_32 -- requirements
Module: fp_ds_32

---
 rtl/fp_ds_32.sv | 180 ++++++++++++++++++
 tb/tb_fp_ds_32.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fp_ds_32.sv
// IEEE-754 binary32 divider: restoring radix-2 mantissa division, one quotient
// bit per cycle, round-to-nearest-even, flush-to-zero for denormals.
module fp_ds_32 (
    input  logic [31:0] Divisor,
    input  logic [31:0] Dividend,
    output logic [31:0] Quotient,
    input  logic        clk,
    input  logic        ready,
    input  logic        rst
);
    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [24:0]        rem_q, rem_d;
    logic [25:0]        quo_q, quo_d;
    logic [23:0]        dvsr_q, dvsr_d;
    logic signed [9:0]  exp_q, exp_d;
    logic               sign_q, sign_d;
    logic               special_q, special_d;
    logic [31:0]        spec_res_q, spec_res_d;
    logic [31:0]        quot_q, quot_d;

    // Operand decode, used only on the load edge
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        sign_in, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        spec_in;
    logic [31:0] spec_val;

    assign ea      = Dividend[30:23];
    assign eb      = Divisor[30:23];
    assign fa      = Dividend[22:0];
    assign fb      = Divisor[22:0];
    assign sign_in = Dividend[31] ^ Divisor[31];
    assign a_nan   = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan   = (eb == 8'hFF) && (fb != 23'd0);
    assign a_inf   = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf   = (eb == 8'hFF) && (fb == 23'd0);
    assign a_zero  = (ea == 8'h00);
    assign b_zero  = (eb == 8'h00);

    always_comb begin
        spec_in  = 1'b1;
        spec_val = 32'h7FC00000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_val = 32'h7FC00000;
        end else if (a_inf || b_zero) begin
            spec_val = {sign_in, 8'hFF, 23'd0};
        end else if (a_zero || b_inf) begin
            spec_val = {sign_in, 31'd0};
        end else begin
            spec_in = 1'b0;
        end
    end

    // One restoring step
    logic        q_bit;
    logic [24:0] rem_sub;
    assign q_bit   = (rem_q >= {1'b0, dvsr_q});
    assign rem_sub = q_bit ? (rem_q - {1'b0, dvsr_q}) : rem_q;

    // Normalize and round the 26-bit quotient (24 bits + guard + round)
    logic [23:0]       mant_n;
    logic              g_bit, r_bit, st_bit, rnd_up;
    logic [24:0]       mant_r;
    logic [22:0]       frac_r;
    logic signed [9:0] exp_n, exp_r;
    logic [31:0]       norm_res;

    always_comb begin
        if (quo_q[25]) begin
            mant_n = quo_q[25:2];
            g_bit  = quo_q[1];
            r_bit  = quo_q[0];
            exp_n  = exp_q;
        end else begin
            mant_n = quo_q[24:1];
            g_bit  = quo_q[0];
            r_bit  = 1'b0;
            exp_n  = exp_q - 10'sd1;
        end
        st_bit = (rem_q != 25'd0);
        rnd_up = g_bit & (r_bit | st_bit | mant_n[0]);
        mant_r = {1'b0, mant_n} + {24'd0, rnd_up};
        exp_r  = mant_r[24] ? (exp_n + 10'sd1) : exp_n;
        frac_r = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
        if (exp_r >= 10'sd255) begin
            norm_res = {sign_q, 8'hFF, 23'd0};
        end else if (exp_r <= 10'sd0) begin
            norm_res = {sign_q, 31'd0};
        end else begin
            norm_res = {sign_q, exp_r[7:0], frac_r};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvsr_d     = dvsr_q;
        exp_d      = exp_q;
        sign_d     = sign_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        quot_d     = quot_q;
        case (state_q)
            IDLE: begin
                if (ready) begin
                    rem_d      = {2'b01, fa};
                    dvsr_d     = {1'b1, fb};
                    quo_d      = 26'd0;
                    cnt_d      = 5'd0;
                    exp_d      = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
                    sign_d     = sign_in;
                    special_d  = spec_in;
                    spec_res_d = spec_val;
                    // Special operands skip the iteration and resolve on the next edge
                    state_d    = spec_in ? ROUND : CALC;
                end
            end
            CALC: begin
                if (!ready) begin
                    state_d = IDLE;
                end else begin
                    quo_d = {quo_q[24:0], q_bit};
                    rem_d = rem_sub << 1;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd25) begin
                        state_d = ROUND;
                    end
                end
            end
            ROUND: begin
                if (!ready) begin
                    state_d = IDLE;
                end else begin
                    quot_d  = special_q ? spec_res_q : norm_res;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            rem_q      <= 25'd0;
            quo_q      <= 26'd0;
            dvsr_q     <= 24'd0;
            exp_q      <= 10'sd0;
            sign_q     <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= 32'd0;
            quot_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvsr_q     <= dvsr_d;
            exp_q      <= exp_d;
            sign_q     <= sign_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            quot_q     <= quot_d;
        end
    end

    assign Quotient = quot_q;

endmodule

// File: tb/tb_fp_ds_32.sv
// Directed and randomized checks of fp_ds_32 against an arithmetic division model.
module tb_fp_ds_32;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] Dividend = 32'd0;
    logic [31:0] Divisor = 32'd0;
    logic [31:0] Quotient;

    int n_checks = 0;
    int n_fail = 0;

    fp_ds_32 dut (
        .Divisor  (Divisor),
        .Dividend (Dividend),
        .Quotient (Quotient),
        .clk      (clk),
        .ready    (ready),
        .rst      (rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference: {special, result} from exact integer division and explicit RNE
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [7:0]  ea, eb;
        logic [63:0] ma, mb, num, q, r, mant, rest, half;
        logic        up;
        int          e;
        s  = a[31] ^ b[31];
        ea = a[30:23];
        eb = b[30:23];
        if ((ea == 8'hFF && a[22:0] != 0) || (eb == 8'hFF && b[22:0] != 0) ||
            (ea == 0 && eb == 0) || (ea == 8'hFF && eb == 8'hFF))
            return {1'b1, 32'h7FC00000};
        if (ea == 8'hFF || eb == 0) return {1'b1, s, 8'hFF, 23'd0};
        if (ea == 0 || eb == 8'hFF) return {1'b1, s, 31'd0};
        ma  = {40'd0, 1'b1, a[22:0]};
        mb  = {40'd0, 1'b1, b[22:0]};
        num = ma << 39;
        q   = num / mb;
        r   = num % mb;
        e   = int'(ea) - int'(eb) + 127;
        if (q >= (64'd1 << 39)) begin
            mant = q >> 16; rest = q & 64'hFFFF; half = 64'h8000;
        end else begin
            e = e - 1;
            mant = q >> 15; rest = q & 64'h7FFF; half = 64'h4000;
        end
        up = (rest > half) || (rest == half && (r != 0 || mant[0]));
        mant = mant + {63'd0, up};
        if (mant == (64'd1 << 24)) begin
            mant = 64'd1 << 23;
            e = e + 1;
        end
        if (e >= 255) return {1'b0, s, 8'hFF, 23'd0};
        if (e <= 0) return {1'b0, s, 31'd0};
        return {1'b0, s, 8'(e), mant[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        int k;
        logic [31:0] v;
        k = $urandom_range(0, 9);
        v = $urandom;
        if (k == 0) begin
            case ($urandom_range(0, 5))
                0: v = 32'h00000000;
                1: v = 32'h80000000;
                2: v = 32'h7F800000;
                3: v = 32'hFF800000;
                4: v = 32'h7FC00001;
                default: v = {v[31], 8'h00, v[22:0]};
            endcase
        end else if (k == 1) begin
            v[30:23] = 8'($urandom_range(1, 254));
        end else begin
            v[30:23] = 8'($urandom_range(100, 154));
        end
        return v;
    endfunction

    // Called at a negedge; returns at the negedge after the result edge, ready still high
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_v,
                           input int lat, input string tag);
        logic [31:0] old;
        old      = Quotient;
        Dividend = a;
        Divisor  = b;
        ready    = 1'b1;
        @(negedge clk);
        Dividend = $urandom;
        Divisor  = $urandom;
        repeat (lat - 2) @(negedge clk);
        check({tag, "_hold"}, Quotient, old);
        @(negedge clk);
        check(tag, Quotient, exp_v);
        $display("div %h / %h -> %h (expect %h, latency %0d) %s", a, b, Quotient, exp_v, lat, tag);
    endtask

    task automatic go_idle();
        ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] old;
        logic [31:0] a, b;
        logic [32:0] m;

        #1 rst = 1'b1;
        #2 check("reset_q", Quotient, 32'h00000000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_div(32'h42B6B000, 32'h3E140000, 32'h441E0000, 28, "basic_632");
        repeat (30) @(negedge clk);
        check("held_high", Quotient, 32'h441E0000);
        ready = 1'b0;
        repeat (30) @(negedge clk);
        check("held_low", Quotient, 32'h441E0000);
        run_div(32'h42B6B000, 32'h3E140000, 32'h441E0000, 28, "recompute_632");
        go_idle();

        run_div(32'h3F800000, 32'h40000000, 32'h3F000000, 28, "one_half");
        go_idle();
        run_div(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28, "one_third");
        go_idle();

        run_div(32'h3F800000, 32'h00000000, 32'h7F800000, 2, "x_div_0");
        go_idle();
        run_div(32'h00000000, 32'h00000000, 32'h7FC00000, 2, "zero_div_zero");
        go_idle();
        run_div(32'h80000000, 32'h40000000, 32'h80000000, 2, "negzero_div");
        go_idle();
        run_div(32'hC0000000, 32'h3F800000, 32'hC0000000, 28, "neg_two");
        go_idle();
        run_div(32'h7F000000, 32'h3F000000, 32'h7F800000, 28, "overflow");
        go_idle();
        run_div(32'h00800000, 32'h40000000, 32'h00000000, 28, "underflow");
        go_idle();

        old      = Quotient;
        Dividend = 32'h40400000;
        Divisor  = 32'h3F800000;
        ready    = 1'b1;
        repeat (10) @(negedge clk);
        ready = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_calc", Quotient, old);
        run_div(32'h42B6B000, 32'h3E140000, 32'h441E0000, 28, "after_abort");
        go_idle();

        Dividend = 32'h3F800000;
        Divisor  = 32'h40400000;
        ready    = 1'b1;
        repeat (27) @(negedge clk);
        ready = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_round", Quotient, 32'h441E0000);

        Dividend = 32'h3F800000;
        Divisor  = 32'h40400000;
        ready    = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1 check("rst_mid_calc", Quotient, 32'h00000000);
        @(negedge clk);
        rst = 1'b0;
        run_div(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28, "restart_after_rst");
        go_idle();

        for (int i = 0; i < 40; i++) begin
            a = rand_op();
            b = rand_op();
            m = ref_div(a, b);
            run_div(a, b, m[31:0], m[32] ? 2 : 28, "random");
            go_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
